sub_pipe: RTL



---
 rtl/sub_pipe_pkg.sv | 13 +
 rtl/sub_chunk.sv | 23 ++
 rtl/sub_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sub_pipe_pkg.sv
// sub_pipe_pkg: shared constants and helpers for the pipelined subtractor.
//   DefWidth / DefChunk : default operand width and per-stage slice width.
//   slice_lo()          : low bit index of CHUNK-aligned slice idx.
package sub_pipe_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefChunk = 8;

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned chunk);
        return idx * chunk;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// sub_chunk: combinational CHUNK-bit subtract slice, o_diff = i_a - i_b - i_bin.
//   i_a, i_b : operand slices (CHUNK bits)
//   i_bin    : borrow in
//   o_diff   : result slice (CHUNK bits)
//   o_bout   : borrow out (1 when i_a < i_b + i_bin)
module sub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_bin,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_bout
);

    // One extra bit catches the borrow as the sign of the widened difference.
    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{CHUNK{1'b0}}, i_bin};
    assign o_diff = w_full[CHUNK-1:0];
    assign o_bout = w_full[CHUNK];

endmodule

// File: rtl/sub_pipe.sv
// sub_pipe: pipelined WIDTH-bit subtractor, diff = a - b - bin, one CHUNK slice per stage.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b, bin)
//   out_valid / out_ready : result handshake (diff, bout, overflow)
//   clr_sticky            : clears ovf_sticky (a simultaneous set wins)
//   ovf_sticky            : set when an overflowing result is consumed
// Latency is STAGES = WIDTH/CHUNK cycles; all stages advance together under one enable.
module sub_pipe
    import sub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CHUNK = DefChunk
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    logic w_en;
    logic r_ovf_sticky;

    // The whole pipe freezes only when a valid result is being held back.
    assign w_en      = out_ready | ~out_valid;
    assign in_ready  = w_en;

    assign out_valid = g_stage[STAGES-1].r_vld;
    assign diff      = g_stage[STAGES-1].r_res;
    assign bout      = g_stage[STAGES-1].r_bor;
    assign overflow  = g_stage[STAGES-1].g_last.r_ovf;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // NIn: operand bits still unresolved entering this stage (current slice and above).
        // NRes: result bits resolved once this stage has registered.
        localparam int unsigned NIn  = WIDTH - slice_lo(k, CHUNK);
        localparam int unsigned NRes = slice_lo(k + 1, CHUNK);

        logic [NIn-1:0]   w_a_in;
        logic [NIn-1:0]   w_b_in;
        logic [NRes-1:0]  w_res;
        logic [CHUNK-1:0] w_d_sl;
        logic             w_vld;
        logic             w_bin;
        logic             w_bout;

        logic             r_vld;
        logic             r_bor;
        logic [NRes-1:0]  r_res;

        if (k == 0) begin : g_head
            assign w_a_in = a;
            assign w_b_in = b;
            assign w_bin  = bin;
            assign w_vld  = in_valid;
            assign w_res  = w_d_sl;
        end else begin : g_body
            assign w_a_in = g_stage[k-1].g_skew.r_a_up;
            assign w_b_in = g_stage[k-1].g_skew.r_b_up;
            assign w_bin  = g_stage[k-1].r_bor;
            assign w_vld  = g_stage[k-1].r_vld;
            // Lower slices ride along so the whole result leaves in one beat.
            assign w_res  = {w_d_sl, g_stage[k-1].r_res};
        end

        sub_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .i_a    (w_a_in[CHUNK-1:0]),
            .i_b    (w_b_in[CHUNK-1:0]),
            .i_bin  (w_bin),
            .o_diff (w_d_sl),
            .o_bout (w_bout)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_bor <= 1'b0;
                r_res <= '0;
            end else if (w_en) begin
                r_vld <= w_vld;
                r_bor <= w_bout;
                r_res <= w_res;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            // Skew registers: operand slices not yet consumed, MSB included.
            logic [NIn-CHUNK-1:0] r_a_up;
            logic [NIn-CHUNK-1:0] r_b_up;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_up <= '0;
                    r_b_up <= '0;
                end else if (w_en) begin
                    r_a_up <= w_a_in[NIn-1:CHUNK];
                    r_b_up <= w_b_in[NIn-1:CHUNK];
                end
            end
        end else begin : g_last
            logic r_ovf;

            // Signed overflow: operand signs differ and the result sign departs from a.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= (w_a_in[NIn-1] != w_b_in[NIn-1]) & (w_d_sl[CHUNK-1] != w_a_in[NIn-1]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (out_valid & out_ready & overflow) begin
            r_ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;

endmodule
